// File: rtl/reg_share_ctl.sv
// ---------------------------------------------------------------------------
// reg_share_ctl
//
// Shares one WIDTH-bit register bank, built from async-clear D flip-flops,
// between NREQ requesters. The block arbitrates write requests, drives the
// bank's D, clock-enable and clear inputs, and sequences a timed clear.
// Each clear holds REG_CLR for CLR_CYCLES cycles, then waits RECOVERY idle
// cycles, and then pulses CLR_ACK. The flop bank itself is outside this block.
//
// Configuration macro:
//   REG_SHARE_RR_EN  defined   -> round-robin arbitration. The search starts
//                                 one past the last grantee.
//                    undefined -> fixed priority. The lowest index wins.
//
// Parameters:
//   NREQ        number of requesters (2..16)
//   WIDTH       register bank width
//   CLR_CYCLES  cycles REG_CLR is held high per clear (>=1)
//   RECOVERY    idle cycles after REG_CLR falls, before writes or ack (>=0)
//
// Ports:
//   C        in   clock; all logic runs on the rising edge
//   CLR_N    in   synchronous active-low reset
//   REQ      in   per-requester write request (level)
//   WDATA    in   write data; requester i occupies bits [i*WIDTH +: WIDTH]
//   CLR_REQ  in   clear request (level)
//   GNT      out  one-hot grant, one-cycle pulse
//   REG_D    out  data to the bank D inputs; holds its value between writes
//   REG_CE   out  bank clock enable
//   REG_CLR  out  bank clear
//   CLR_ACK  out  one-cycle pulse when a clear completes
//   BUSY     out  high while clearing or recovering
// ---------------------------------------------------------------------------
module reg_share_ctl #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 8,
    parameter int CLR_CYCLES = 2,
    parameter int RECOVERY   = 1
) (
    input  logic                    C,
    input  logic                    CLR_N,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*WIDTH-1:0]   WDATA,
    input  logic                    CLR_REQ,
    output logic [NREQ-1:0]         GNT,
    output logic [WIDTH-1:0]        REG_D,
    output logic                    REG_CE,
    output logic                    REG_CLR,
    output logic                    CLR_ACK,
    output logic                    BUSY
);

    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (CLR_CYCLES > RECOVERY) ? CLR_CYCLES : RECOVERY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    // The counters are loaded with (length - 1). They count down to zero and
    // never wrap, so the state that holds zero is the last cycle of its phase.
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = (RECOVERY > 0) ? CNT_W'(RECOVERY - 1) : '0;
    localparam bit               NO_RECOVER = (RECOVERY == 0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] start_idx;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             exit_now;
    logic             do_grant;

`ifdef REG_SHARE_RR_EN
    // The pointer holds the next index to search from. Resetting it to 0
    // means the first contention after reset is won by requester 0.
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge C) begin
        if (!CLR_N) begin
            rr_ptr <= '0;
        end else if (do_grant) begin
            if (win_idx == IDX_W'(NREQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= win_idx + IDX_W'(1);
        end
    end

    assign start_idx = rr_ptr;
`else
    assign start_idx = '0;
`endif

    // Rotating search for the first active request, beginning at start_idx.
    // Fixed-priority mode is the same search with a constant start of 0.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(start_idx) + i;
            if (cand >= NREQ)
                cand = cand - NREQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && REQ[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // exit_now marks the last cycle of a clear sequence. On that edge the
    // controller returns to IDLE. A waiting requester is granted on the same
    // edge, so the grant lines up with CLR_ACK. CLR_REQ is ignored on that
    // edge because the requester has not yet seen its acknowledge.
    assign exit_now = ((state == ST_CLEAR) && (cnt == '0) && NO_RECOVER) ||
                      ((state == ST_RECOVER) && (cnt == '0));

    assign do_grant = win_found && (((state == ST_IDLE) && !CLR_REQ) || exit_now);

    // Clear sequencer: IDLE -> CLEAR -> RECOVER -> IDLE. When RECOVERY is 0,
    // CLEAR returns straight to IDLE. A reset in the middle of a clear drops
    // REG_CLR and produces no acknowledge.
    always_ff @(posedge C) begin
        if (!CLR_N) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            REG_CLR <= 1'b0;
            BUSY    <= 1'b0;
            CLR_ACK <= 1'b0;
        end else begin
            CLR_ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CLR_REQ) begin
                        state   <= ST_CLEAR;
                        cnt     <= CLR_LOAD;
                        REG_CLR <= 1'b1;
                        BUSY    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == '0) begin
                        REG_CLR <= 1'b0;
                        if (NO_RECOVER) begin
                            state   <= ST_IDLE;
                            BUSY    <= 1'b0;
                            CLR_ACK <= 1'b1;
                        end else begin
                            state <= ST_RECOVER;
                            cnt   <= REC_LOAD;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RECOVER: begin
                    if (cnt == '0) begin
                        state   <= ST_IDLE;
                        BUSY    <= 1'b0;
                        CLR_ACK <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    REG_CLR <= 1'b0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

    // Write path. GNT and REG_CE are one-cycle pulses. REG_D keeps the last
    // written value, so the bank D inputs do not toggle while no write is
    // happening.
    always_ff @(posedge C) begin
        if (!CLR_N) begin
            GNT    <= '0;
            REG_CE <= 1'b0;
            REG_D  <= '0;
        end else begin
            GNT    <= '0;
            REG_CE <= 1'b0;
            if (do_grant) begin
                GNT    <= NREQ'(1) << win_idx;
                REG_CE <= 1'b1;
                REG_D  <= WDATA[int'(win_idx)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_reg_share_ctl.sv
// ---------------------------------------------------------------------------
// tb_reg_share_ctl
//
// Testbench for reg_share_ctl. A reference model reacts to each sampled edge.
// It pushes the expected grant and acknowledge events into a queue, and it
// publishes the expected clear, busy and data levels for the current cycle.
// A monitor runs on the falling edge: it pops the queue whenever the DUT
// presents a grant or an acknowledge, and it compares the levels every cycle.
// Arbitration follows REG_SHARE_RR_EN in the same way as the design does.
// ---------------------------------------------------------------------------
module tb_reg_share_ctl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CC    = 2;
    localparam int REC   = 1;

    logic                  C = 1'b0;
    logic                  CLR_N;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] WDATA;
    logic                  CLR_REQ;
    logic [NREQ-1:0]       GNT;
    logic [WIDTH-1:0]      REG_D;
    logic                  REG_CE;
    logic                  REG_CLR;
    logic                  CLR_ACK;
    logic                  BUSY;

    always #5 C = ~C;

    reg_share_ctl #(
        .NREQ(NREQ), .WIDTH(WIDTH), .CLR_CYCLES(CC), .RECOVERY(REC)
    ) dut (
        .C(C), .CLR_N(CLR_N), .REQ(REQ), .WDATA(WDATA), .CLR_REQ(CLR_REQ),
        .GNT(GNT), .REG_D(REG_D), .REG_CE(REG_CE), .REG_CLR(REG_CLR),
        .CLR_ACK(CLR_ACK), .BUSY(BUSY)
    );

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] g;
        logic            ack;
    } ev_t;

    ev_t exp_q[$];

    // Requester-side stimulus state
    bit               req_pend [NREQ];
    logic [WIDTH-1:0] req_data [NREQ];
    bit               clr_v;
    bit               clrn_v;
    bit               hold_all;
    bit               clr_sticky;
    bit               rand_en;

    // Reference model state
    int               edge_n    = 0;
    int               exit_edge = -1;
    int               clr_start = 0;
    int               last_gnt  = NREQ - 1;
    bit               exp_clr;
    bit               exp_busy;
    logic [WIDTH-1:0] exp_d;
    logic [NREQ-1:0]  granted_now;
    bit               ack_now;

    int check_cnt = 0;
    int pass_cnt  = 0;
    bit mon_on    = 0;

    task automatic check(input string name, input bit ok, input string msg);
        check_cnt++;
        if (ok)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: %s", name, msg);
    endtask

    function automatic bit bit_at(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // Winner selection. Round-robin starts one past the previous winner;
    // fixed priority takes the lowest requesting index.
    function automatic int pick_winner();
`ifdef REG_SHARE_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last_gnt + k) % NREQ;
            if (bit_at(REQ, idx)) return idx;
        end
`else
        for (int i = 0; i < NREQ; i++)
            if (bit_at(REQ, i)) return i;
`endif
        return -1;
    endfunction

    // The model runs on each rising edge, using the input values that the
    // DUT samples on that edge. Its outputs describe the cycle that follows.
    task automatic model_step();
        int w;
        edge_n++;
        granted_now = '0;
        ack_now     = 1'b0;
        if (CLR_N !== 1'b1) begin
            exp_clr   = 1'b0;
            exp_busy  = 1'b0;
            exp_d     = '0;
            exit_edge = -1;
            last_gnt  = NREQ - 1;
            return;
        end
        if (exit_edge >= 0 && edge_n < exit_edge) begin
            exp_busy = 1'b1;
            exp_clr  = (edge_n < clr_start + CC);
            return;
        end
        exp_busy = 1'b0;
        exp_clr  = 1'b0;
        if (exit_edge >= 0) begin
            ack_now   = 1'b1;
            exit_edge = -1;
        end else if (CLR_REQ === 1'b1) begin
            clr_start = edge_n;
            exit_edge = edge_n + CC + REC;
            exp_busy  = 1'b1;
            exp_clr   = 1'b1;
            return;
        end
        w = pick_winner();
        if (w >= 0) begin
            granted_now = NREQ'(1) << w;
            exp_d       = WDATA[w*WIDTH +: WIDTH];
            last_gnt    = w;
        end
        if (granted_now != '0 || ack_now)
            exp_q.push_back('{edge_n, granted_now, ack_now});
    endtask

    task automatic drive_pins();
        CLR_N   = clrn_v;
        CLR_REQ = clr_v;
        for (int i = 0; i < NREQ; i++) begin
            REQ[i]                 = req_pend[i];
            WDATA[i*WIDTH +: WIDTH] = req_data[i];
        end
    endtask

    // Requesters follow the handshake: a requester drops REQ once it is
    // granted, and a clear requester drops CLR_REQ when it sees CLR_ACK
    // (unless it is deliberately held for a repeat clear).
    task automatic apply_stimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (hold_all)
                req_pend[i] = 1'b1;
            else if (bit_at(granted_now, i))
                req_pend[i] = 1'b0;
            else if (rand_en && !req_pend[i] && $urandom_range(0, 9) < 3) begin
                req_pend[i] = 1'b1;
                req_data[i] = WIDTH'($urandom);
            end
        end
        if (ack_now && !clr_sticky)
            clr_v = 1'b0;
        else if (rand_en && !clr_v && $urandom_range(0, 49) == 0)
            clr_v = 1'b1;
        if (rand_en)
            clrn_v = ($urandom_range(0, 299) != 0);
        drive_pins();
    endtask

    task automatic tick();
        @(posedge C);
        model_step();
        #1;
        apply_stimulus();
    endtask

    task automatic check_output();
        bit   present;
        bit   ok;
        ev_t  e;
        ok = (REG_CLR === exp_clr) && (BUSY === exp_busy) && (REG_D === exp_d) &&
             !(REG_CE === 1'b1 && REG_CLR === 1'b1);
        check("levels", ok, $sformatf("cyc %0d got clr=%b busy=%b d=%h ce=%b, want clr=%b busy=%b d=%h",
              edge_n, REG_CLR, BUSY, REG_D, REG_CE, exp_clr, exp_busy, exp_d));
        while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
            check("missed_event", 1'b0, $sformatf("cyc %0d got nothing, want gnt=%b ack=%b",
                  exp_q[0].cyc, exp_q[0].g, exp_q[0].ack));
            void'(exp_q.pop_front());
        end
        present = (GNT !== '0) || (CLR_ACK !== 1'b0) || (REG_CE !== 1'b0);
        if (present) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1'b0, $sformatf("cyc %0d got gnt=%b ack=%b ce=%b, want none",
                      edge_n, GNT, CLR_ACK, REG_CE));
            end else begin
                e  = exp_q.pop_front();
                ok = (e.cyc == edge_n) && (GNT === e.g) && (CLR_ACK === e.ack) &&
                     (REG_CE === (e.g != '0));
                check("grant_ack", ok, $sformatf("cyc %0d got gnt=%b ack=%b ce=%b, want cyc %0d gnt=%b ack=%b",
                      edge_n, GNT, CLR_ACK, REG_CE, e.cyc, e.g, e.ack));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
            check("missing_out", 1'b0, $sformatf("cyc %0d got gnt=%b ack=%b, want gnt=%b ack=%b",
                  edge_n, GNT, CLR_ACK, exp_q[0].g, exp_q[0].ack));
            void'(exp_q.pop_front());
        end
    endtask

    always @(negedge C)
        if (mon_on) check_output();

    task automatic wait_drained();
        for (int n = 0; n < 30; n++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) any |= req_pend[i];
            if (!any && !clr_v) return;
            tick();
        end
    endtask

    initial begin
        bit found;
        // Reset is held for three edges while every request and a clear are
        // active; after release only the clear may start.
        for (int i = 0; i < NREQ; i++) begin
            req_pend[i] = 1'b1;
            req_data[i] = WIDTH'($urandom);
        end
        clr_v      = 1'b1;
        clrn_v     = 1'b0;
        hold_all   = 1'b0;
        clr_sticky = 1'b0;
        rand_en    = 1'b0;
        granted_now = '0;
        ack_now    = 1'b0;
        drive_pins();
        tick();
        mon_on = 1'b1;
        tick();
        tick();
        clrn_v = 1'b1;
        drive_pins();
        repeat (20) tick();

        // Single write from requester 2
        wait_drained();
        req_pend[2] = 1'b1;
        req_data[2] = 8'hA5;
        drive_pins();
        repeat (4) tick();

        // All requesters held high
        hold_all = 1'b1;
        drive_pins();
        repeat (9) tick();
        hold_all = 1'b0;
        wait_drained();

        // Clear and write arrive on the same edge
        clr_v       = 1'b1;
        req_pend[1] = 1'b1;
        req_data[1] = WIDTH'($urandom);
        drive_pins();
        repeat (8) tick();

        // CLR_REQ held through the acknowledge: back-to-back clears
        wait_drained();
        clr_sticky = 1'b1;
        clr_v      = 1'b1;
        drive_pins();
        repeat (10) tick();
        clr_sticky = 1'b0;
        wait_drained();

        // Reset asserted in the second REG_CLR cycle
        clr_v = 1'b1;
        drive_pins();
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            tick();
            if (exit_edge >= 0 && edge_n == clr_start + 1) found = 1'b1;
        end
        check("reach_clear", found, $sformatf("got found=%b, want 1", found));
        clrn_v = 1'b0;
        clr_v  = 1'b0;
        drive_pins();
        tick();
        clrn_v = 1'b1;
        drive_pins();
        repeat (8) tick();

        // Randomised traffic with occasional clears and resets
        rand_en = 1'b1;
        repeat (3000) tick();
        rand_en = 1'b0;
        clrn_v  = 1'b1;
        drive_pins();
        repeat (40) tick();

        @(negedge C);
        #1;
        check("queue_drained", exp_q.size() == 0,
              $sformatf("got %0d pending events, want 0", exp_q.size()));
        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/reg_share_ctl.md
# reg_share_ctl

Controller that shares one WIDTH-bit register bank, built from async-clear D flip-flops, between NREQ requesters. Arbitrates write requests, drives the bank's D, clock-enable and clear inputs, and sequences a timed clear with recovery gap and acknowledge. Sits between requesting logic and the flop bank; the bank itself is outside this block.

## Interface
- NREQ, 4: number of requesters (2..16)
- WIDTH, 8: register bank width
- CLR_CYCLES, 2: cycles REG_CLR is held high per clear (>=1)
- RECOVERY, 1: idle cycles after REG_CLR falls before writes or ack (>=0)

- C  in  1  clock, all logic on rising edge
- CLR_N  in  1  reset, synchronous, active-low
- REQ  in  NREQ  per-requester write request (level)
- WDATA  in  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
- CLR_REQ  in  1  clear request (level)
- GNT  out  NREQ  one-hot grant, one-cycle pulse
- REG_D  out  WIDTH  data to bank D inputs
- REG_CE  out  1  bank clock enable
- REG_CLR  out  1  bank clear
- CLR_ACK  out  1  one-cycle pulse on clear completion
- BUSY  out  1  high in CLEAR or RECOVER

## Operation
- States: IDLE, CLEAR, RECOVER. All outputs registered.
- IDLE, CLR_REQ=1: go to CLEAR; clear takes priority over any REQ that cycle, no grant issued.
- IDLE, CLR_REQ=0, any REQ=1: pick winner, assert GNT[winner]=1, REG_CE=1, REG_D=WDATA slice of winner for exactly one cycle; stay IDLE. Grants may issue on consecutive cycles.
- IDLE, nothing requested: GNT=0, REG_CE=0, REG_D holds last value.
- CLEAR: REG_CLR=1 for CLR_CYCLES cycles, REG_CE=0, GNT=0; then RECOVER (or IDLE with CLR_ACK if RECOVERY=0).
- RECOVER: REG_CLR=0, no grants for RECOVERY cycles; last cycle exits to IDLE with CLR_ACK=1 on the first IDLE cycle.
- CLR_REQ still high in the cycle CLR_ACK is high starts a new clear sequence; requesters deassert CLR_REQ upon CLR_ACK.
- REQ held during CLEAR/RECOVER is not lost; evaluated normally on return to IDLE.
- Requester keeps REQ and WDATA stable until its GNT; a requester may re-request the cycle after GNT.
- Internal cycle counter sized to max(CLR_CYCLES, RECOVERY); counts down, no wrap.

## Timing
- Reset (CLR_N=0 at edge): state IDLE, GNT=0, REG_D=0, REG_CE=0, REG_CLR=0, CLR_ACK=0, BUSY=0, arbitration pointer=0, counter=0.
- Reset mid-clear: REG_CLR drops after that edge, no CLR_ACK is produced.
- REQ sampled at edge k: GNT/REG_CE/REG_D valid in cycle k+1; bank captures at edge k+2.
- CLR_REQ sampled at edge k: REG_CLR high cycles k+1..k+CLR_CYCLES, BUSY high for same span plus RECOVERY, CLR_ACK high in cycle k+CLR_CYCLES+RECOVERY+1, first grant earliest in that same cycle.
- REG_CE and REG_CLR never high in the same cycle.

## Configuration
- REG_SHARE_RR_EN defined: round-robin; search starts at last grantee+1 modulo NREQ; pointer updates only on a grant; clears leave pointer unchanged.
- Not defined: fixed priority, lowest index wins; pointer logic absent.

## Test plan
- Reset: hold CLR_N=0 for 3 cycles with REQ=4'b1111, CLR_REQ=1 -> all outputs 0 throughout and one cycle after release only clear starts (REG_CLR=1).
- Single write: REQ=4'b0100, WDATA slice 2=8'hA5 -> next cycle GNT=4'b0100, REG_CE=1, REG_D=8'hA5, one cycle only.
- Contention, REG_SHARE_RR_EN on: REQ=4'b1111 held -> grants 0,1,2,3,0 on consecutive cycles; macro off -> GNT=4'b0001 every cycle.
- Clear vs write same edge: CLR_REQ=1, REQ=4'b0010 -> no GNT; REG_CLR high 2 cycles, 1 recovery cycle, CLR_ACK pulse with GNT=4'b0010 in same cycle.
- Repeat clear: CLR_REQ held high through CLR_ACK -> second REG_CLR 2-cycle pulse begins the following cycle.
- Reset during CLEAR: CLR_N=0 in 2nd REG_CLR cycle -> REG_CLR=0, BUSY=0 next cycle, CLR_ACK never asserted.
